// File: rtl/pcie_disp_pkg.sv
// Shared PCIe lane definitions: symbol widths, K-code bytes, scrambler polynomial and helpers.
package pcie_disp_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned LFSR_W = 16;

    // x^16 + x^5 + x^4 + x^3 + 1, Galois feedback into bits 0,3,4,5
    localparam logic [LFSR_W-1:0] SCR_TAPS         = 16'h0039;
    localparam logic [LFSR_W-1:0] SCR_SEED_DEFAULT = 16'hFFFF;

    typedef enum logic [BYTE_W-1:0] {
        K_SKP = 8'h1C,
        K_FTS = 8'h3C,
        K_SDP = 8'h5C,
        K_IDL = 8'h7C,
        K_COM = 8'hBC,
        K_PAD = 8'hF7,
        K_STP = 8'hFB,
        K_END = 8'hFD,
        K_EDB = 8'hFE
    } k_code_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              k;
    } tx_sym_t;

    // Eight serial steps of the scrambler LFSR
    function automatic logic [LFSR_W-1:0] lfsr_adv8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[LFSR_W-2:0], 1'b0} ^ (r[LFSR_W-1] ? SCR_TAPS : '0);
        end
        return r;
    endfunction

    // Byte bit i is the LFSR MSB on serial step i, i.e. s[15-i]
    function automatic logic [BYTE_W-1:0] scr_byte(input logic [LFSR_W-1:0] s);
        return {s[8], s[9], s[10], s[11], s[12], s[13], s[14], s[15]};
    endfunction

endpackage

// File: rtl/enc_8b10b.sv
// Combinational 8b/10b encoder; illegal K values are replaced by K28.5 and flagged.
module enc_8b10b
    import pcie_disp_pkg::*;
(
    input  tx_sym_t            sym,
    input  logic               rd_in,
    output logic [SYM_W-1:0]   code_c,
    output logic               rd_c,
    output logic               bad_k_c
);

    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k;
    logic [5:0] six_base;
    logic [3:0] four_base;
    logic       six_unbal;
    logic       four_unbal;
    logic       rd_mid;
    logic       alt7;
    logic       six_flip;
    logic       four_flip;

    always_comb begin
        legal_k = (sym.data[4:0] == 5'd28) ||
                  ((sym.data[7:5] == 3'd7) && (sym.data[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30}));
        bad_k_c = sym.k && !legal_k;
        {y, x}  = bad_k_c ? BYTE_W'(K_COM) : sym.data;

        // 5b/6b in RD- form (abcdei)
        six_base = '0;
        case (x)
            5'd0:  six_base = 6'b100111;
            5'd1:  six_base = 6'b011101;
            5'd2:  six_base = 6'b101101;
            5'd3:  six_base = 6'b110001;
            5'd4:  six_base = 6'b110101;
            5'd5:  six_base = 6'b101001;
            5'd6:  six_base = 6'b011001;
            5'd7:  six_base = 6'b111000;
            5'd8:  six_base = 6'b111001;
            5'd9:  six_base = 6'b100101;
            5'd10: six_base = 6'b010101;
            5'd11: six_base = 6'b110100;
            5'd12: six_base = 6'b001101;
            5'd13: six_base = 6'b101100;
            5'd14: six_base = 6'b011100;
            5'd15: six_base = 6'b010111;
            5'd16: six_base = 6'b011011;
            5'd17: six_base = 6'b100011;
            5'd18: six_base = 6'b010011;
            5'd19: six_base = 6'b110010;
            5'd20: six_base = 6'b001011;
            5'd21: six_base = 6'b101010;
            5'd22: six_base = 6'b011010;
            5'd23: six_base = 6'b111010;
            5'd24: six_base = 6'b110011;
            5'd25: six_base = 6'b100110;
            5'd26: six_base = 6'b010110;
            5'd27: six_base = 6'b110110;
            5'd28: six_base = 6'b001110;
            5'd29: six_base = 6'b101110;
            5'd30: six_base = 6'b011110;
            5'd31: six_base = 6'b101011;
        endcase
        if (sym.k && (x == 5'd28)) begin
            six_base = 6'b001111;
        end

        six_unbal = ($countones(six_base) != 3);
        six_flip  = rd_in && (six_unbal || (!sym.k && (x == 5'd7)));
        rd_mid    = rd_in ^ six_unbal;

        alt7 = !sym.k && (y == 3'd7) &&
               ((!rd_mid && (x inside {5'd17, 5'd18, 5'd20})) ||
                ( rd_mid && (x inside {5'd11, 5'd13, 5'd14})));

        // 3b/4b in RD- form (fghj)
        four_base = '0;
        if (sym.k) begin
            case (y)
                3'd0: four_base = 4'b1011;
                3'd1: four_base = 4'b0110;
                3'd2: four_base = 4'b1010;
                3'd3: four_base = 4'b1100;
                3'd4: four_base = 4'b1101;
                3'd5: four_base = 4'b0101;
                3'd6: four_base = 4'b1001;
                3'd7: four_base = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0: four_base = 4'b1011;
                3'd1: four_base = 4'b1001;
                3'd2: four_base = 4'b0101;
                3'd3: four_base = 4'b1100;
                3'd4: four_base = 4'b1101;
                3'd5: four_base = 4'b1010;
                3'd6: four_base = 4'b0110;
                3'd7: four_base = alt7 ? 4'b0111 : 4'b1110;
            endcase
        end

        four_unbal = ($countones(four_base) != 2);
        four_flip  = rd_mid && (sym.k || four_unbal || (y == 3'd3));

        code_c = {six_flip ? ~six_base : six_base, four_flip ? ~four_base : four_base};
        rd_c   = rd_mid ^ four_unbal;
    end

endmodule

// File: rtl/tx_lane_disp.sv
// Single-lane PCIe Tx: scrambler, 8b/10b encode with running disparity, registered symbol out.
// Define TXLANE_BITREV_EN to emit the symbol LSB-first ({j,h,g,f,i,e,d,c,b,a}).
module tx_lane_disp
    import pcie_disp_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SCRAMBLE_SEED = SCR_SEED_DEFAULT,
    parameter logic              RD_INIT       = 1'b0
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [BYTE_W-1:0] TxByte,
    input  logic              TxControl,
    input  logic              TxTrainingSeq,
    input  logic              DisableScramble,
    input  logic              InvertTxPolarity,
    input  logic              ElecIdle,
    output logic [SYM_W-1:0]  LinkOut,
    output logic              RunDisp,
    output logic              BadControl
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [SYM_W-1:0]  link_out_q, link_out_d;
    logic              run_disp_q, run_disp_d;
    logic              bad_control_q, bad_control_d;

    tx_sym_t           enc_in;
    logic [SYM_W-1:0]  enc_code;
    logic              enc_rd;
    logic              enc_bad;
    logic [SYM_W-1:0]  pol_code;
    logic [SYM_W-1:0]  lane_code;

    // Scrambler XOR on data only; training-set bodies and bypass go through untouched
    always_comb begin
        enc_in.k    = TxControl;
        enc_in.data = TxByte;
        if (!TxControl && !DisableScramble && !TxTrainingSeq) begin
            enc_in.data = TxByte ^ scr_byte(lfsr_q);
        end
    end

    enc_8b10b u_enc (
        .sym     (enc_in),
        .rd_in   (run_disp_q),
        .code_c  (enc_code),
        .rd_c    (enc_rd),
        .bad_k_c (enc_bad)
    );

    always_comb begin
        lfsr_d        = lfsr_q;
        link_out_d    = '0;
        run_disp_d    = run_disp_q;
        bad_control_d = 1'b0;

        pol_code = enc_code ^ {SYM_W{InvertTxPolarity}};
`ifdef TXLANE_BITREV_EN
        for (int i = 0; i < SYM_W; i++) begin
            lane_code[i] = pol_code[SYM_W-1-i];
        end
`else
        lane_code = pol_code;
`endif

        // Idle drives zeros and freezes disparity so the next symbol resumes seamlessly
        if (!ElecIdle) begin
            link_out_d    = lane_code;
            run_disp_d    = enc_rd;
            bad_control_d = enc_bad;
        end

        if (TxControl && (TxByte == BYTE_W'(K_COM))) begin
            lfsr_d = SCRAMBLE_SEED;
        end else if (TxControl && (TxByte == BYTE_W'(K_SKP))) begin
            lfsr_d = lfsr_q;
        end else if (!ElecIdle) begin
            lfsr_d = lfsr_adv8(lfsr_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q        <= SCRAMBLE_SEED;
            link_out_q    <= '0;
            run_disp_q    <= RD_INIT;
            bad_control_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            link_out_q    <= link_out_d;
            run_disp_q    <= run_disp_d;
            bad_control_q <= bad_control_d;
        end
    end

    assign LinkOut    = link_out_q;
    assign RunDisp    = run_disp_q;
    assign BadControl = bad_control_q;

endmodule

// File: tb/tb_tx_lane_disp.sv
// Self-checking bench for tx_lane_disp: directed protocol vectors plus randomized traffic vs a reference model.
module tb_tx_lane_disp;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] TxByte = 8'h00;
    logic       TxControl = 1'b0;
    logic       TxTrainingSeq = 1'b0;
    logic       DisableScramble = 1'b0;
    logic       InvertTxPolarity = 1'b0;
    logic       ElecIdle = 1'b0;
    logic [9:0] LinkOut;
    logic       RunDisp;
    logic       BadControl;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_lfsr = 'hFFFF;
    bit m_rd   = 1'b0;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] TD4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] TK4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                           8'hF7, 8'hFB, 8'hFD, 8'hFE};

    tx_lane_disp dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .TxByte           (TxByte),
        .TxControl        (TxControl),
        .TxTrainingSeq    (TxTrainingSeq),
        .DisableScramble  (DisableScramble),
        .InvertTxPolarity (InvertTxPolarity),
        .ElecIdle         (ElecIdle),
        .LinkOut          (LinkOut),
        .RunDisp          (RunDisp),
        .BadControl       (BadControl)
    );

    always #5 Clk = ~Clk;

    // Serial scrambler: XOR bit i is the MSB at step i, then shift with feedback
    function automatic void scr_model(input int s_in, output int xb, output int s_out);
        int s;
        s  = s_in;
        xb = 0;
        for (int i = 0; i < 8; i++) begin
            xb = xb | (((s >> 15) & 1) << i);
            s  = ((s << 1) & 'hFFFF) ^ ((((s >> 15) & 1) != 0) ? 'h0039 : 0);
        end
        s_out = s;
    endfunction

    // Choose the sub-block form that drives disparity back toward neutral
    function automatic void sub_block(input int t, input int w, input bit special, inout bit rd, output int v);
        int mask;
        int ones;
        int pos;
        mask = (1 << w) - 1;
        ones = $countones(t);
        pos  = (2 * ones < w) ? (~t & mask) : t;
        if ((2 * ones == w) && !special) v = t;
        else v = rd ? (~pos & mask) : pos;
        if (2 * ones != w) rd = !rd;
    endfunction

    function automatic void model_encode(input logic [7:0] b_in, input bit k, inout bit rd,
                                         output logic [9:0] code, output bit bad);
        int x;
        int y;
        int t6;
        int t4;
        int v6;
        int v4;
        bit alt;
        x   = int'(b_in) % 32;
        y   = int'(b_in) / 32;
        bad = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (bad) begin
            x = 28;
            y = 5;
        end
        t6 = (k && x == 28) ? 'h0F : int'(T6[x]);
        sub_block(t6, 6, !k && x == 7, rd, v6);
        alt = !k && y == 7 && ((!rd && (x == 17 || x == 18 || x == 20)) ||
                               ( rd && (x == 11 || x == 13 || x == 14)));
        t4 = k ? int'(TK4[y]) : (alt ? 'h7 : int'(TD4[y]));
        sub_block(t4, 4, k || y == 3, rd, v4);
        code = 10'(v6 * 16 + v4);
    endfunction

    function automatic logic [9:0] shape(input logic [9:0] c, input bit inv);
        logic [9:0] r;
        r = inv ? ~c : c;
`ifdef TXLANE_BITREV_EN
        r = {<<{r}};
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input bit ctl, input bit ts, input bit dis,
                        input bit inv, input bit idle, input string tag);
        int         xb;
        int         s_next;
        logic [7:0] sb;
        logic [9:0] code;
        logic [9:0] e_link;
        bit         bad;
        bit         rd_tmp;
        bit         e_rd;
        bit         e_bad;
        scr_model(m_lfsr, xb, s_next);
        sb     = (!ctl && !dis && !ts) ? (b ^ 8'(xb)) : b;
        rd_tmp = m_rd;
        model_encode(sb, ctl, rd_tmp, code, bad);
        if (idle) begin
            e_link = 10'h000;
            e_rd   = m_rd;
            e_bad  = 1'b0;
        end else begin
            e_link = shape(code, inv);
            e_rd   = rd_tmp;
            e_bad  = bad;
            m_rd   = rd_tmp;
        end
        if (ctl && b == 8'hBC) m_lfsr = 'hFFFF;
        else if ((ctl && b == 8'h1C) || idle) m_lfsr = m_lfsr;
        else m_lfsr = s_next;

        TxByte           = b;
        TxControl        = ctl;
        TxTrainingSeq    = ts;
        DisableScramble  = dis;
        InvertTxPolarity = inv;
        ElecIdle         = idle;
        @(posedge Clk);
        #1;
        check({tag, "/link"}, LinkOut, e_link);
        check({tag, "/rd"}, 10'(RunDisp), 10'(e_rd));
        check({tag, "/bad"}, 10'(BadControl), 10'(e_bad));
    endtask

    task automatic do_reset(input string tag);
        Reset     = 1'b1;
        TxByte    = 8'hBC;
        TxControl = 1'b1;
        ElecIdle  = 1'b0;
        @(posedge Clk);
        #1;
        check({tag, "/link"}, LinkOut, 10'h000);
        check({tag, "/rd"}, 10'(RunDisp), 10'd0);
        check({tag, "/bad"}, 10'(BadControl), 10'd0);
        Reset  = 1'b0;
        m_lfsr = 'hFFFF;
        m_rd   = 1'b0;
    endtask

    initial begin
        bit         rd_before;
        logic [7:0] rb;
        bit         rc;

        do_reset("reset");

        step(8'hBC, 1, 0, 0, 0, 0, "com1");
        check("com1_const", LinkOut, shape(10'h0FA, 0));
        check("com1_rd", 10'(RunDisp), 10'd1);
        step(8'h00, 0, 0, 0, 0, 0, "d00a");
        check("d00a_const", LinkOut, shape(10'h14E, 0));

        step(8'hBC, 1, 0, 0, 0, 0, "com2");
        check("com2_const", LinkOut, shape(10'h305, 0));
        step(8'h00, 0, 0, 0, 0, 0, "d00b");
        check("d00b_const", LinkOut, shape(10'h2B1, 0));

        step(8'hBC, 1, 0, 0, 0, 0, "com3");
        step(8'h1C, 1, 0, 0, 0, 0, "skp");
        check("skp_const", LinkOut, shape(10'h30B, 0));
        step(8'h00, 0, 0, 0, 0, 0, "d00c");
        check("d00c_const", LinkOut, shape(10'h14E, 0));

        step(8'hBC, 1, 0, 0, 0, 0, "com4");
        step(8'h4A, 0, 1, 0, 0, 0, "ts");
        check("ts_const", LinkOut, shape(10'h155, 0));
        step(8'h00, 0, 0, 0, 0, 0, "d17");
        check("d17_const", LinkOut, shape(10'h3A4, 0));

        step(8'h00, 1, 0, 0, 0, 0, "badk");
        check("badk_pulse", 10'(BadControl), 10'd1);
        step(8'hBC, 1, 0, 0, 0, 0, "com5");
        check("badk_clear", 10'(BadControl), 10'd0);

        step(8'hBC, 1, 0, 0, 1, 0, "inv");
        rd_before = m_rd;
        for (int i = 0; i < 5; i++) begin
            step(8'($urandom), 0, 0, 0, i[0], 1, "idle");
            check("idle_zero", LinkOut, 10'h000);
        end
        step(8'hB5, 0, 0, 1, 0, 0, "d21_5");
        check("d21_5_const", LinkOut, shape(10'h2AA, 0));
        check("d21_5_rd", 10'(RunDisp), 10'(rd_before));

        step(8'h5A, 0, 0, 0, 0, 0, "pre_rst");
        do_reset("midreset");
        step(8'h00, 0, 0, 0, 0, 0, "post_rst");
        check("post_rst_const", LinkOut, shape(10'h2B1, 0));

        for (int n = 0; n < 400; n++) begin
            int r;
            r  = int'($urandom_range(0, 99));
            rc = (r < 20);
            if (r < 5) rb = 8'hBC;
            else if (r < 9) rb = 8'h1C;
            else if (r < 20) rb = LEGAL_K[$urandom_range(0, 11)];
            else rb = 8'($urandom);
            step(rb, rc, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
